beat_sequencer: RTL and testbench

- Generates the 9-bit `ibeat` beat index and a one-cycle `beat_tick` strobe for the slot-machine music and LED paths.
- The LED controller and tone table consume `ibeat`. They flash and select notes from it, so this block is the producing end of the `ibeat` interface.
- The tempo comes from a programmable clock divider.
- Playback is controlled by start/pause/stop commands from the game FSM, with an optional loop-at-end.

---
 rtl/beat_sequencer.sv | 153 +++++++++++++++
 tb/tb_beat_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_sequencer.sv
// -----------------------------------------------------------------------------
// beat_sequencer
//   Produces the beat index (ibeat_o) and a one-cycle beat strobe for the
//   slot-machine music and LED paths. The tempo comes from a divider whose
//   period is BEAT_DIV >> tempo_sel_i cycles. tempo_sel_i = 3 behaves as 2.
//   Playback is driven by start/pause/stop pulses, with an optional
//   loop-at-end.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      pulse: play from beat 0
//   pause_i      pulse: toggle PLAY <-> HOLD
//   stop_i       pulse: abort to IDLE
//   loop_en_i    level: wrap at BEAT_MAX instead of finishing
//   tempo_sel_i  divider shift (0..2, 3 treated as 2)
//   ibeat_o      current beat index (registered)
//   beat_tick_o  one-cycle strobe on the cycle ibeat_o advances
//   playing_o    high while in PLAY
//   done_o       high while in DONE
// -----------------------------------------------------------------------------
module beat_sequencer #(
  parameter int unsigned BEAT_DIV = 12_500_000,
  parameter int unsigned BEAT_MAX = 511
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       stop_i,
  input  logic       loop_en_i,
  input  logic [1:0] tempo_sel_i,
  output logic [8:0] ibeat_o,
  output logic       beat_tick_o,
  output logic       playing_o,
  output logic       done_o
);

  localparam logic [23:0] DIV_L = 24'(BEAT_DIV);
  localparam logic [8:0]  MAX_L = 9'(BEAT_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [23:0] count_q;
  logic [8:0]  ibeat_q;
  logic        tick_q;
  logic        playing_q;
  logic        done_q;

  logic [1:0]  shift_d;
  logic [23:0] limit_d;
  logic [23:0] term_at_d;
  logic        terminal_d;
  logic        below_max_d;

  // Terminal uses >= so that switching to a faster tempo mid-beat
  // ends the beat at once instead of running the counter past the limit.
  always_comb begin
    shift_d     = (tempo_sel_i == 2'd3) ? 2'd2 : tempo_sel_i;
    limit_d     = DIV_L >> shift_d;
    term_at_d   = (limit_d == 24'd0) ? 24'd0 : (limit_d - 24'd1);
    terminal_d  = (count_q >= term_at_d);
    below_max_d = (ibeat_q < MAX_L);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      count_q   <= 24'd0;
      ibeat_q   <= 9'd0;
      tick_q    <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (stop_i) begin
        state_q   <= S_IDLE;
        count_q   <= 24'd0;
        ibeat_q   <= 9'd0;
        playing_q <= 1'b0;
        done_q    <= 1'b0;
      end else if (start_i) begin
        // Same action from every state, including a restart while playing.
        state_q   <= S_PLAY;
        count_q   <= 24'd0;
        ibeat_q   <= 9'd0;
        playing_q <= 1'b1;
        done_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            count_q <= 24'd0;
            ibeat_q <= 9'd0;
          end
          S_PLAY: begin
            if (terminal_d) begin
              // A pause on a terminal cycle still lets the beat complete.
              count_q <= 24'd0;
              tick_q  <= 1'b1;
              if (below_max_d) begin
                ibeat_q <= ibeat_q + 9'd1;
              end else if (loop_en_i) begin
                ibeat_q <= 9'd0;
              end
              if (pause_i) begin
                state_q   <= S_HOLD;
                playing_q <= 1'b0;
              end else if (!below_max_d && !loop_en_i) begin
                state_q   <= S_DONE;
                playing_q <= 1'b0;
                done_q    <= 1'b1;
              end
            end else if (pause_i) begin
              // Count freezes at its current value; resume continues from it.
              state_q   <= S_HOLD;
              playing_q <= 1'b0;
            end else begin
              count_q <= count_q + 24'd1;
            end
          end
          S_HOLD: begin
            if (pause_i) begin
              state_q   <= S_PLAY;
              playing_q <= 1'b1;
            end
          end
          S_DONE: begin
            ibeat_q <= MAX_L;
          end
          default: begin
            state_q   <= S_IDLE;
            count_q   <= 24'd0;
            ibeat_q   <= 9'd0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ibeat_o     = ibeat_q;
  assign beat_tick_o = tick_q;
  assign playing_o   = playing_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// -----------------------------------------------------------------------------
// tb_beat_sequencer
//   Self-checking bench for beat_sequencer with BEAT_DIV=8, BEAT_MAX=7.
//   A behavioural model tracks the play mode, the beat number and the cycles
//   elapsed in the current beat; every cycle the DUT outputs are compared
//   against it. Directed scenarios add explicit constant checks.
// -----------------------------------------------------------------------------
module tb_beat_sequencer;

  localparam int DIV  = 8;
  localparam int LAST = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       pause;
  logic       stop;
  logic       loop_en;
  logic [1:0] tempo_sel;
  logic [8:0] ibeat;
  logic       beat_tick;
  logic       playing;
  logic       done;

  always #5 clk = ~clk;

  beat_sequencer #(
    .BEAT_DIV(DIV),
    .BEAT_MAX(LAST)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .pause_i     (pause),
    .stop_i      (stop),
    .loop_en_i   (loop_en),
    .tempo_sel_i (tempo_sel),
    .ibeat_o     (ibeat),
    .beat_tick_o (beat_tick),
    .playing_o   (playing),
    .done_o      (done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tick_seen = 0;
  bit done_seen = 1'b0;

  // Model: mode names are for readability only.
  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_HOLD = 2;
  localparam int M_DONE = 3;
  int m_mode;
  int m_beat;
  int m_elapsed;   // cycles already spent in the current beat
  bit m_tick;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_beat = 0; m_elapsed = 0; m_tick = 1'b0;
  endtask

  // One rising edge of the reference behaviour.
  task automatic model_edge();
    int sel;
    int period;
    sel    = (int'(tempo_sel) > 2) ? 2 : int'(tempo_sel);
    period = DIV / (2 ** sel);
    m_tick = 1'b0;
    if (stop) begin
      m_mode = M_IDLE; m_beat = 0; m_elapsed = 0;
    end else if (start) begin
      m_mode = M_PLAY; m_beat = 0; m_elapsed = 0;
    end else if (m_mode == M_PLAY) begin
      if (m_elapsed + 1 >= period) begin
        bit finished;
        finished  = (m_beat == LAST) && !loop_en;
        m_tick    = 1'b1;
        m_elapsed = 0;
        if (m_beat < LAST) m_beat = m_beat + 1;
        else if (loop_en)  m_beat = 0;
        if (pause)         m_mode = M_HOLD;
        else if (finished) m_mode = M_DONE;
      end else if (pause) begin
        m_mode = M_HOLD;
      end else begin
        m_elapsed = m_elapsed + 1;
      end
    end else if (m_mode == M_HOLD && pause) begin
      m_mode = M_PLAY;
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, ".ibeat"},   int'(ibeat),     m_beat);
    check({where, ".tick"},    int'(beat_tick), int'(m_tick));
    check({where, ".playing"}, int'(playing),   (m_mode == M_PLAY) ? 1 : 0);
    check({where, ".done"},    int'(done),      (m_mode == M_DONE) ? 1 : 0);
  endtask

  // Drive one cycle of commands (called just after a falling edge).
  task automatic cycle(input bit st, input bit pa, input bit sp);
    start = st; pause = pa; stop = sp;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (beat_tick) tick_seen++;
    if (done) done_seen = 1'b1;
    check_outputs("cyc");
    start = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    loop_en = 1'b0; tempo_sel = 2'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;

    // Reset and start: 8 beats of 8 cycles, then DONE holding beat 7.
    tick_seen = 0;
    cycle(1'b1, 1'b0, 1'b0);
    check("start.playing", int'(playing), 1);
    idle_cycles(63);
    check("play.ibeat_at_7", int'(ibeat), 7);
    check("play.not_done_yet", int'(done), 0);
    idle_cycles(1);
    check("play.last_tick", int'(beat_tick), 1);
    check("play.done", int'(done), 1);
    idle_cycles(10);
    check("play.hold_7", int'(ibeat), 7);
    check("play.tick_count", tick_seen, 8);
    $display("scenario reset/start: %0d checks so far", n_checks);

    // Loop: after beat 7 the next tick wraps to 0, never DONE.
    loop_en = 1'b1; done_seen = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(64);
    check("loop.wrap_tick", int'(beat_tick), 1);
    check("loop.wrap_ibeat", int'(ibeat), 0);
    idle_cycles(24);
    check("loop.ibeat_after", int'(ibeat), 3);
    check("loop.never_done", int'(done_seen), 0);
    loop_en = 1'b0;
    $display("scenario loop: %0d checks so far", n_checks);

    // Tempo 2: a tick every 2 cycles.
    tempo_sel = 2'd2;
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(1);
    check("tempo2.no_tick", int'(beat_tick), 0);
    idle_cycles(1);
    check("tempo2.tick", int'(beat_tick), 1);
    idle_cycles(4);
    check("tempo2.ibeat", int'(ibeat), 3);

    // Tempo switch 0 -> 2 with count at 5: immediate tick, then every 2.
    tempo_sel = 2'd0;
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(5);
    tempo_sel = 2'd2;
    idle_cycles(1);
    check("switch.tick_now", int'(beat_tick), 1);
    check("switch.ibeat1", int'(ibeat), 1);
    idle_cycles(1);
    check("switch.gap", int'(beat_tick), 0);
    idle_cycles(1);
    check("switch.tick2", int'(beat_tick), 1);
    check("switch.ibeat2", int'(ibeat), 2);
    tempo_sel = 2'd3;   // behaves as 2
    idle_cycles(2);
    check("tempo3.ibeat3", int'(ibeat), 3);
    tempo_sel = 2'd0;
    $display("scenario tempo: %0d checks so far", n_checks);

    // Pause at count 3 with beat 2, hold 20 cycles, resume.
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(19);
    check("pause.pre_ibeat", int'(ibeat), 2);
    cycle(1'b0, 1'b1, 1'b0);
    check("pause.held", int'(playing), 0);
    idle_cycles(20);
    check("pause.ibeat_frozen", int'(ibeat), 2);
    cycle(1'b0, 1'b1, 1'b0);
    check("resume.playing", int'(playing), 1);
    tick_seen = 0;
    idle_cycles(4);
    check("resume.no_early_tick", tick_seen, 0);
    idle_cycles(1);
    check("resume.tick_at_5", int'(beat_tick), 1);
    check("resume.ibeat", int'(ibeat), 3);
    $display("scenario pause: %0d checks so far", n_checks);

    // Priority: start+stop in PLAY -> IDLE.
    cycle(1'b1, 1'b1, 1'b1);
    check("prio.idle_playing", int'(playing), 0);
    check("prio.idle_ibeat", int'(ibeat), 0);
    idle_cycles(10);
    check("prio.stays_idle", int'(ibeat), 0);
    // Start in DONE -> PLAY from 0.
    cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(66);
    check("prio.in_done", int'(done), 1);
    cycle(1'b1, 1'b0, 1'b0);
    check("prio.restart_playing", int'(playing), 1);
    check("prio.restart_ibeat", int'(ibeat), 0);
    check("prio.restart_done", int'(done), 0);
    $display("scenario priority: %0d checks so far", n_checks);

    // Asynchronous reset between edges.
    idle_cycles(11);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("areset.ibeat", int'(ibeat), 0);
    check("areset.playing", int'(playing), 0);
    check("areset.tick", int'(beat_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(12);
    check("areset.stays_idle", int'(playing), 0);
    $display("scenario async reset: %0d checks so far", n_checks);

    // Randomized commands, loop and tempo against the model.
    for (int i = 0; i < 4000; i++) begin
      int r;
      bit st, pa, sp;
      r  = int'($urandom_range(0, 199));
      st = (r < 3) || (r == 199);
      sp = (r == 3) || (r == 199);
      pa = (r >= 4 && r < 10) || (r == 199) || (r == 198);
      if ($urandom_range(0, 59) == 0) loop_en = 1'($urandom);
      if ($urandom_range(0, 79) == 0) tempo_sel = 2'($urandom_range(0, 3));
      cycle(st, pa, sp);
    end
    $display("scenario random: %0d checks so far", n_checks);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
